// File: rtl/input_conditioner_pkg.sv
// Shared constants and helpers for the input conditioner (synchroniser, debounce, press pulses).
package input_conditioner_pkg;

  localparam int unsigned SYNC_STAGES_DEFAULT     = 2;
  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 100000;
  localparam int unsigned REPEAT_CYCLES_DEFAULT   = 5000000;

  // Ceiling log2, floored at 1 so it can always size a counter.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) result = i + 1;
    end
    return (result == 0) ? 1 : result;
  endfunction

endpackage

// File: rtl/input_conditioner_if.sv
// Raw board inputs and conditioned outputs of the input conditioner, bundled as one interface.
interface input_conditioner_if #(
  parameter int unsigned N_DIPs = 16,
  parameter int unsigned N_PBs  = 3
);
  logic [N_DIPs-1:0] DIP_raw;
  logic [N_PBs-1:0]  PB_raw;
  logic [N_DIPs-1:0] DIP;
  logic [N_PBs-1:0]  PB;
  logic [N_PBs-1:0]  PB_pressed;
  logic              DIP_changed;

  modport master (
    output DIP_raw, PB_raw,
    input  DIP, PB, PB_pressed, DIP_changed
  );

  modport slave (
    input  DIP_raw, PB_raw,
    output DIP, PB, PB_pressed, DIP_changed
  );
endinterface

// File: rtl/debounce_vec.sv
// Synchroniser plus shared-counter debouncer for a vector of inputs; pulses changed on each update.
module debounce_vec
  import input_conditioner_pkg::*;
#(
  parameter int unsigned WIDTH           = 1,
  parameter int unsigned SYNC_STAGES     = SYNC_STAGES_DEFAULT,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] raw,
  output logic [WIDTH-1:0] stable,
  output logic             changed
);

  localparam int unsigned     CNT_W    = clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0]                  sync;
  logic [WIDTH-1:0]                  sync_prev_q;
  logic [WIDTH-1:0]                  stable_q, stable_d;
  logic [CNT_W-1:0]                  cnt_q, cnt_d;
  logic                              changed_q, changed_d;

  assign sync    = sync_q[SYNC_STAGES-1];
  assign stable  = stable_q;
  assign changed = changed_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q      <= '0;
      sync_prev_q <= '0;
      stable_q    <= '0;
      cnt_q       <= '0;
      changed_q   <= 1'b0;
    end else begin
      sync_q      <= {sync_q[SYNC_STAGES-2:0], raw};
      sync_prev_q <= sync;
      stable_q    <= stable_d;
      cnt_q       <= cnt_d;
      changed_q   <= changed_d;
    end
  end

  // Any bounce, or agreement with the held value, restarts the count; never wraps.
  always_comb begin
    cnt_d     = cnt_q;
    stable_d  = stable_q;
    changed_d = 1'b0;
    if (sync != sync_prev_q) begin
      cnt_d = '0;
    end else if (sync == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      stable_d  = sync;
      cnt_d     = '0;
      changed_d = 1'b1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/input_conditioner.sv
// Conditions DIP switches and pushbuttons: sync, debounce, press pulses, DIP change pulse.
// Define PB_AUTOREPEAT_EN to add periodic PB_pressed pulses while a button is held.
module input_conditioner
  import input_conditioner_pkg::*;
#(
  parameter int unsigned N_DIPs          = 16,
  parameter int unsigned N_PBs           = 3,
  parameter int unsigned SYNC_STAGES     = SYNC_STAGES_DEFAULT,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int unsigned REPEAT_CYCLES   = REPEAT_CYCLES_DEFAULT
) (
  input  logic                CLK,
  input  logic                RESET,
  input_conditioner_if.slave  bus
);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || DEBOUNCE_CYCLES == 0 || REPEAT_CYCLES == 0)
  begin : g_param_check
    $error("input_conditioner: parameter out of range");
  end

  logic [N_PBs-1:0] pb_stable;
  logic [N_PBs-1:0] pb_changed;
  logic [N_PBs-1:0] pb_press;

  debounce_vec #(
    .WIDTH           (N_DIPs),
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_dip (
    .clk     (CLK),
    .rst_n   (RESET),
    .raw     (bus.DIP_raw),
    .stable  (bus.DIP),
    .changed (bus.DIP_changed)
  );

  for (genvar i = 0; i < N_PBs; i++) begin : g_pb
    debounce_vec #(
      .WIDTH           (1),
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_pb (
      .clk     (CLK),
      .rst_n   (RESET),
      .raw     (bus.PB_raw[i]),
      .stable  (pb_stable[i]),
      .changed (pb_changed[i])
    );
  end

  // A change that leaves the button at 1 is a press; releases are silent.
  assign pb_press = pb_changed & pb_stable;
  assign bus.PB   = pb_stable;

`ifdef PB_AUTOREPEAT_EN
  localparam int unsigned      RPT_W    = clog2(REPEAT_CYCLES);
  localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_CYCLES - 1);

  logic [N_PBs-1:0][RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
  logic [N_PBs-1:0]            rpt_pulse_q, rpt_pulse_d;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      rpt_cnt_q   <= '0;
      rpt_pulse_q <= '0;
    end else begin
      rpt_cnt_q   <= rpt_cnt_d;
      rpt_pulse_q <= rpt_pulse_d;
    end
  end

  always_comb begin
    rpt_cnt_d   = rpt_cnt_q;
    rpt_pulse_d = '0;
    for (int i = 0; i < N_PBs; i++) begin
      if (!pb_stable[i]) begin
        rpt_cnt_d[i] = '0;
      end else if (rpt_cnt_q[i] == RPT_LAST) begin
        rpt_cnt_d[i]   = '0;
        rpt_pulse_d[i] = 1'b1;
      end else begin
        rpt_cnt_d[i] = rpt_cnt_q[i] + 1'b1;
      end
    end
  end

  // Mask a repeat that would land in the cycle the button reads released.
  assign bus.PB_pressed = pb_press | (rpt_pulse_q & pb_stable);
`else
  assign bus.PB_pressed = pb_press;
`endif

endmodule

// File: tb/tb_input_conditioner.sv
// Scoreboard bench for input_conditioner: expected pulses are queued at stimulus time.
module tb_input_conditioner;

  localparam int unsigned N_DIPS = 16;
  localparam int unsigned N_PBS  = 3;
  localparam int unsigned SYNC   = 2;
  localparam int unsigned DEB    = 4;
  localparam int unsigned RPT    = 8;
  localparam int          LAT    = SYNC + DEB;

  logic CLK   = 1'b0;
  logic RESET = 1'b1;

  input_conditioner_if #(.N_DIPs(N_DIPS), .N_PBs(N_PBS)) bus ();

  input_conditioner #(
    .N_DIPs          (N_DIPS),
    .N_PBs           (N_PBS),
    .SYNC_STAGES     (SYNC),
    .DEBOUNCE_CYCLES (DEB),
    .REPEAT_CYCLES   (RPT)
  ) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct { int cyc; logic [15:0] val; } dip_ev_t;
  typedef struct { int cyc; logic [2:0]  mask; } pb_ev_t;

  dip_ev_t dip_q[$];
  pb_ev_t  pb_q[$];
  dip_ev_t de;
  pb_ev_t  pe;

  // Pulse monitor: every pulse must match the head of its queue, in cycle and value.
  always @(posedge CLK) begin
    #1;
    if (bus.DIP_changed !== 1'b0) begin
      checks++;
      if (dip_q.size() == 0) begin
        errors++;
        $display("FAIL dip_changed_unexpected cyc=%0d DIP=%h", cyc, bus.DIP);
      end else begin
        de = dip_q.pop_front();
        if (cyc != de.cyc || bus.DIP !== de.val) begin
          errors++;
          $display("FAIL dip_changed_event got cyc=%0d DIP=%h want cyc=%0d DIP=%h",
                   cyc, bus.DIP, de.cyc, de.val);
        end
      end
    end else if (dip_q.size() != 0 && dip_q[0].cyc < cyc) begin
      checks++;
      errors++;
      de = dip_q.pop_front();
      $display("FAIL dip_changed_missed got none want cyc=%0d DIP=%h", de.cyc, de.val);
    end

    if (bus.PB_pressed !== 3'b000) begin
      checks++;
      if (pb_q.size() == 0) begin
        errors++;
        $display("FAIL pb_pressed_unexpected cyc=%0d PB_pressed=%b", cyc, bus.PB_pressed);
      end else begin
        pe = pb_q.pop_front();
        if (cyc != pe.cyc || bus.PB_pressed !== pe.mask) begin
          errors++;
          $display("FAIL pb_pressed_event got cyc=%0d mask=%b want cyc=%0d mask=%b",
                   cyc, bus.PB_pressed, pe.cyc, pe.mask);
        end
      end
    end else if (pb_q.size() != 0 && pb_q[0].cyc < cyc) begin
      checks++;
      errors++;
      pe = pb_q.pop_front();
      $display("FAIL pb_pressed_missed got none want cyc=%0d mask=%b", pe.cyc, pe.mask);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic test_reset();
    int n;
    tick(3);
    checks++;
    if (bus.DIP !== 16'h0000) begin
      errors++; $display("FAIL reset_dip got %h want 0000", bus.DIP);
    end
    checks++;
    if (bus.DIP_changed !== 1'b0) begin
      errors++; $display("FAIL reset_dip_changed got %b want 0", bus.DIP_changed);
    end
    checks++;
    if (bus.PB !== 3'b000) begin
      errors++; $display("FAIL reset_pb got %b want 000", bus.PB);
    end
    checks++;
    if (bus.PB_pressed !== 3'b000) begin
      errors++; $display("FAIL reset_pb_pressed got %b want 000", bus.PB_pressed);
    end
    RESET = 1'b1;
    n = cyc;
    dip_q.push_back('{n + 1 + LAT, 16'hFFFF});
    tick(LAT);
    checks++;
    if (bus.DIP !== 16'h0000) begin
      errors++; $display("FAIL release_dip_early got %h want 0000", bus.DIP);
    end
    tick(1);
    checks++;
    if (bus.DIP !== 16'hFFFF || bus.DIP_changed !== 1'b1) begin
      errors++;
      $display("FAIL release_dip_update got %h/%b want FFFF/1", bus.DIP, bus.DIP_changed);
    end
    tick(1);
    checks++;
    if (bus.DIP_changed !== 1'b0) begin
      errors++; $display("FAIL release_dip_changed_width got %b want 0", bus.DIP_changed);
    end
  endtask

  task automatic test_glitch();
    bus.DIP_raw = 16'hAAAA;
    tick(2);
    bus.DIP_raw = 16'hFFFF;
    tick(12);
    checks++;
    if (bus.DIP !== 16'hFFFF) begin
      errors++; $display("FAIL glitch_dip got %h want FFFF", bus.DIP);
    end
  endtask

  task automatic test_bounce();
    int n;
    n = 0;
    for (int k = 0; k < 10; k++) begin
      bus.DIP_raw = 16'h5555 ^ 16'((k / 2) % 2);
      if (k == 8) begin
        n = cyc;
        dip_q.push_back('{n + 1 + LAT, 16'h5555});
      end
      tick(1);
    end
    tick(n + LAT - cyc);
    checks++;
    if (bus.DIP !== 16'hFFFF) begin
      errors++; $display("FAIL bounce_dip_early got %h want FFFF", bus.DIP);
    end
    tick(1);
    checks++;
    if (bus.DIP !== 16'h5555) begin
      errors++; $display("FAIL bounce_dip_update got %h want 5555", bus.DIP);
    end
    tick(4);
  endtask

  task automatic test_pb_press();
    int n;
    int fall;
    n = cyc;
    bus.PB_raw = 3'b101;
    fall = n + 20 + 1 + LAT;
    pb_q.push_back('{n + 1 + LAT, 3'b101});
`ifdef PB_AUTOREPEAT_EN
    for (int t = n + 1 + LAT + RPT; t < fall; t += RPT) pb_q.push_back('{t, 3'b101});
`endif
    tick(LAT);
    checks++;
    if (bus.PB !== 3'b000) begin
      errors++; $display("FAIL pb_early got %b want 000", bus.PB);
    end
    tick(1);
    checks++;
    if (bus.PB !== 3'b101) begin
      errors++; $display("FAIL pb_level got %b want 101", bus.PB);
    end
    tick(20 - LAT - 1);
    bus.PB_raw = 3'b000;
    tick(fall - 1 - cyc);
    checks++;
    if (bus.PB !== 3'b101) begin
      errors++; $display("FAIL pb_release_early got %b want 101", bus.PB);
    end
    tick(1);
    checks++;
    if (bus.PB !== 3'b000) begin
      errors++; $display("FAIL pb_release got %b want 000", bus.PB);
    end
    tick(4);
  endtask

  task automatic test_reset_mid();
    int m;
    bus.PB_raw = 3'b010;
    tick(5);
    checks++;
    if (dut.g_pb[1].u_pb.cnt_q == '0) begin
      errors++; $display("FAIL midcount_cnt_running got 0 want nonzero");
    end
    #2 RESET = 1'b0;
    #1;
    checks++;
    if (bus.PB !== 3'b000 || bus.PB_pressed !== 3'b000) begin
      errors++;
      $display("FAIL midreset_pb got %b/%b want 000/000", bus.PB, bus.PB_pressed);
    end
    checks++;
    if (dut.g_pb[1].u_pb.cnt_q != '0) begin
      errors++; $display("FAIL midreset_cnt got %0d want 0", dut.g_pb[1].u_pb.cnt_q);
    end
    checks++;
    if (bus.DIP !== 16'h0000) begin
      errors++; $display("FAIL midreset_dip got %h want 0000", bus.DIP);
    end
    tick(2);
    RESET = 1'b1;
    m = cyc;
    pb_q.push_back('{m + 1 + LAT, 3'b010});
    dip_q.push_back('{m + 1 + LAT, 16'h5555});
    tick(LAT);
    checks++;
    if (bus.PB !== 3'b000) begin
      errors++; $display("FAIL postreset_pb_early got %b want 000", bus.PB);
    end
    tick(1);
    checks++;
    if (bus.PB !== 3'b010) begin
      errors++; $display("FAIL postreset_pb got %b want 010", bus.PB);
    end
    bus.PB_raw = 3'b000;
    tick(LAT + 4);
  endtask

`ifdef PB_AUTOREPEAT_EN
  task automatic test_autorepeat();
    int n;
    n = cyc;
    bus.PB_raw = 3'b001;
    for (int k = 0; k < 4; k++) pb_q.push_back('{n + 1 + LAT + k * RPT, 3'b001});
    tick(30);
    bus.PB_raw = 3'b000;
    tick(LAT + RPT + 4);
    checks++;
    if (bus.PB !== 3'b000) begin
      errors++; $display("FAIL autorepeat_release got %b want 000", bus.PB);
    end
  endtask
`endif

  initial begin
    bus.DIP_raw = 16'hFFFF;
    bus.PB_raw  = 3'b000;
    #1 RESET = 1'b0;
    test_reset();
    test_glitch();
    test_bounce();
    test_pb_press();
    test_reset_mid();
`ifdef PB_AUTOREPEAT_EN
    test_autorepeat();
`endif
    tick(10);
    checks++;
    if (dip_q.size() != 0 || pb_q.size() != 0) begin
      errors++;
      $display("FAIL pending_events got dip=%0d pb=%0d want 0/0", dip_q.size(), pb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/input_conditioner.md
Name: input_conditioner

Overview:
- Sits directly upstream of Wrapper, between the board DIP switches/pushbuttons and Wrapper's DIP and PB inputs.
- Synchronises every raw input to CLK and debounces it.
- Produces single-cycle press pulses for pushbuttons and a change pulse for the DIP bank.
- The processor therefore reads clean, stable values through lw regardless of when the user touches a switch.

Parameters:
- N_DIPs, 16, number of DIP switch inputs.
- N_PBs, 3, number of pushbutton inputs.
- SYNC_STAGES, 2, flip-flops in each synchroniser chain (legal range 2..4).
- DEBOUNCE_CYCLES, 100000, consecutive stable cycles required before an output updates (benches use 4).
- REPEAT_CYCLES, 5000000, auto-repeat period; only used when PB_AUTOREPEAT_EN is defined.

Ports:
- CLK  in  1  system clock.
- RESET  in  1  asynchronous, active-low reset (asserted when 0).
- DIP_raw  in  N_DIPs  unsynchronised switch levels.
- PB_raw  in  N_PBs  unsynchronised button levels, 1 = pressed.
- DIP  out  N_DIPs  debounced switch levels; feeds Wrapper DIP.
- PB  out  N_PBs  debounced button levels; feeds Wrapper PB.
- PB_pressed  out  N_PBs  one-cycle pulse per bit on a debounced 0->1 transition.
- DIP_changed  out  1  one-cycle pulse whenever the debounced DIP vector takes a new value.

Behaviour:
- Reset: while RESET=0, all synchroniser flops, stable registers, counters and pulse outputs are cleared to 0, immediately and without waiting for CLK. DIP, PB, PB_pressed and DIP_changed all read 0. After release, the first rising edge samples normally.
- Synchroniser: SYNC_STAGES-deep flop chain per bit. sync = last stage; sync_prev = sync delayed one cycle.
- Debounce, DIP bank: one shared counter cnt_d, width clog2(DEBOUNCE_CYCLES+1). Evaluated each cycle in priority order:
  (a) sync != sync_prev on any bit: cnt_d <= 0.
  (b) else if sync == DIP: cnt_d <= 0.
  (c) else if cnt_d == DEBOUNCE_CYCLES-1: DIP <= sync, cnt_d <= 0, DIP_changed <= 1 for one cycle.
  (d) else cnt_d <= cnt_d + 1.
- Debounce, pushbuttons: same rule, with an independent counter per PB bit.
- Latency: a raw change held steady updates the output exactly SYNC_STAGES + DEBOUNCE_CYCLES rising edges after the first edge that samples it.
- Glitches: a raw pulse shorter than DEBOUNCE_CYCLES cycles never reaches the outputs. A bounce restarts the count from 0.
- Simultaneous events:
  - Several DIP bits changing together, or within the debounce window, produce one DIP update and one DIP_changed pulse.
  - PB bits are fully independent; two buttons may pulse in the same cycle.
- PB_pressed[i] is asserted in the same cycle that PB[i] first reads 1. Release (1->0) produces no pulse.
- Counters saturate logically via the reset-on-match rule and never wrap.
- Reset mid-count discards the pending change. After release, the input must again be stable for the full latency.

Optional Feature:
- Macro: PB_AUTOREPEAT_EN.
- When defined: while PB[i] stays 1, a per-bit repeat counter emits an additional PB_pressed[i] pulse every REPEAT_CYCLES cycles, the first one REPEAT_CYCLES cycles after the initial pulse. The counter clears when PB[i] returns to 0 or on reset.
- When undefined: exactly one pulse per press; no repeat counters are synthesised.

Decomposition:
- Shared package input_conditioner_pkg:
  - default constants for SYNC_STAGES, DEBOUNCE_CYCLES and REPEAT_CYCLES;
  - a function clog2 for counter widths.
- One sub-module, debounce_vec, parameterised by width. It contains the synchroniser, the shared counter, the stable register and the change pulse.
- Instantiated once with width N_DIPs for the DIP bank and N_PBs times with width 1 for the buttons.
- Edge-pulse and auto-repeat logic stays in the top module.

Test Plan (DEBOUNCE_CYCLES=4, SYNC_STAGES=2, REPEAT_CYCLES=8):
- Hold RESET=0 with DIP_raw=16'hFFFF; release and hold -> DIP=0 during reset; DIP=16'hFFFF exactly 6 edges after release; DIP_changed high for exactly that one cycle.
- DIP_raw 16'hAAAA for 2 cycles, then back to the prior value -> DIP unchanged; DIP_changed never asserted.
- DIP_raw=16'h5555 with bit 0 toggling every 2 cycles for 10 cycles, then steady -> DIP=16'h5555 exactly 6 edges after the last toggle; one DIP_changed pulse.
- PB_raw=3'b101 held 20 cycles, then 0 -> PB_pressed=3'b101 for one cycle at the 6th edge; no pulse on release (macro undefined); PB returns to 0 six edges after release.
- PB_raw[1] held and RESET asserted 3 cycles into the count -> PB, PB_pressed and the counter are 0 at once; no pulse until 6 edges after RESET deasserts.
- With PB_AUTOREPEAT_EN defined, PB_raw[0] held 30 cycles -> PB_pressed[0] pulses at cycles 6, 14, 22, 30; stops after release.
